// File: rtl/pe_tile_scheduler_pkg.sv
// Shared constants for the PE tile scheduler: FSM encodings (equal to top_level_state values)
// and peArray geometry.
package pe_tile_scheduler_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_CALC   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int PE_LAT = 3;
    localparam int TN     = 16;
    localparam int TM     = 4;

    // Last CALC count: the streamed pixels plus the peArray pipeline drain.
    function automatic logic [8:0] calc_last(input logic [7:0] ts);
        return {1'b0, ts} + 9'(PE_LAT);
    endfunction

endpackage

// File: rtl/pe_tile_scheduler.sv
// Sequences one convolution tile through peArray: weight loads, pixel streaming per
// input group, and psum-buffer handoff per output group.
module pe_tile_scheduler
    import pe_tile_scheduler_pkg::*;
#(
    parameter int IG_W = 4,
    parameter int OG_W = 4,
    parameter int DA_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           cfg_tile_size,
    input  logic [IG_W-1:0]      cfg_in_grp,
    input  logic [OG_W-1:0]      cfg_out_grp,
    input  logic [7:0]           cfg_pb_base,
    output logic                 w_req,
    output logic [IG_W+OG_W-1:0] w_grp,
    input  logic                 w_ack,
    output logic                 d_re,
    output logic [DA_W-1:0]      d_ra,
    output logic [2:0]           top_level_state,
    output logic [7:0]           pb_addr,
    output logic                 new_tile,
    output logic [7:0]           tile_size,
    input  logic                 pe_finish_flg,
    output logic                 post_req,
    input  logic                 post_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout
);

    logic [2:0]      state_q, state_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [IG_W-1:0] ig_q, ig_d;
    logic [OG_W-1:0] og_q, og_d;
    logic [DA_W-1:0] ig_base_q, ig_base_d;
    logic [7:0]      tile_size_q, tile_size_d;
    logic [7:0]      pb_base_q, pb_base_d;
    logic [IG_W-1:0] in_grp_q, in_grp_d;
    logic [OG_W-1:0] out_grp_q, out_grp_d;
    logic            err_q, err_d;
    logic [DA_W-1:0] ig_step;

    // Each input group occupies tile_size+1 consecutive data-buffer words.
    assign ig_step = DA_W'(tile_size_q) + DA_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ig_d        = ig_q;
        og_d        = og_q;
        ig_base_d   = ig_base_q;
        tile_size_d = tile_size_q;
        pb_base_d   = pb_base_q;
        in_grp_d    = in_grp_q;
        out_grp_d   = out_grp_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD_W;
                    tile_size_d = cfg_tile_size;
                    pb_base_d   = cfg_pb_base;
                    in_grp_d    = cfg_in_grp;
                    out_grp_d   = cfg_out_grp;
                    ig_d        = '0;
                    og_d        = '0;
                    ig_base_d   = '0;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            end
            ST_LOAD_W: begin
                if (w_ack) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                // The schedule never stalls: a missing finish flag is only recorded.
                if (cnt_q == calc_last(tile_size_q)) begin
                    if (!pe_finish_flg) begin
                        err_d = 1'b1;
                    end
                    if (ig_q < in_grp_q) begin
                        ig_d      = ig_q + 1'b1;
                        ig_base_d = ig_base_q + ig_step;
                        state_d   = ST_LOAD_W;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (post_ack) begin
                    if (og_q < out_grp_q) begin
                        og_d      = og_q + 1'b1;
                        ig_d      = '0;
                        ig_base_d = '0;
                        state_d   = ST_LOAD_W;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ig_q        <= '0;
            og_q        <= '0;
            ig_base_q   <= '0;
            tile_size_q <= '0;
            pb_base_q   <= '0;
            in_grp_q    <= '0;
            out_grp_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ig_q        <= ig_d;
            og_q        <= og_d;
            ig_base_q   <= ig_base_d;
            tile_size_q <= tile_size_d;
            pb_base_q   <= pb_base_d;
            in_grp_q    <= in_grp_d;
            out_grp_q   <= out_grp_d;
            err_q       <= err_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them immediately.
    assign top_level_state = state_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign w_req           = (state_q == ST_LOAD_W);
    assign post_req        = (state_q == ST_FLUSH);
    assign w_grp           = {og_q, ig_q};
    assign d_re            = (state_q == ST_CALC) && (cnt_q <= {1'b0, tile_size_q});
    assign d_ra            = d_re ? (ig_base_q + DA_W'(cnt_q)) : '0;
    assign new_tile        = (state_q == ST_CALC) && (ig_q == '0);
    assign tile_size       = tile_size_q;
    assign pb_addr         = pb_base_q;
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Directed self-checking bench for pe_tile_scheduler; expected values are computed
// from the tile configuration of each run.
module tb_pe_tile_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_tile_size;
    logic [3:0]  cfg_in_grp;
    logic [3:0]  cfg_out_grp;
    logic [7:0]  cfg_pb_base;
    logic        w_req;
    logic [7:0]  w_grp;
    logic        w_ack;
    logic        d_re;
    logic [11:0] d_ra;
    logic [2:0]  top_level_state;
    logic [7:0]  pb_addr;
    logic        new_tile;
    logic [7:0]  tile_size;
    logic        pe_finish_flg;
    logic        post_req;
    logic        post_ack;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int total;
    int bad;

    pe_tile_scheduler #(.IG_W(4), .OG_W(4), .DA_W(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_tile_size  (cfg_tile_size),
        .cfg_in_grp     (cfg_in_grp),
        .cfg_out_grp    (cfg_out_grp),
        .cfg_pb_base    (cfg_pb_base),
        .w_req          (w_req),
        .w_grp          (w_grp),
        .w_ack          (w_ack),
        .d_re           (d_re),
        .d_ra           (d_ra),
        .top_level_state(top_level_state),
        .pb_addr        (pb_addr),
        .new_tile       (new_tile),
        .tile_size      (tile_size),
        .pe_finish_flg  (pe_finish_flg),
        .post_req       (post_req),
        .post_ack       (post_ack),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int ts, input int in_grp, input int out_grp, input int pb);
        @(negedge clk);
        cfg_tile_size = 8'(ts);
        cfg_in_grp    = 4'(in_grp);
        cfg_out_grp   = 4'(out_grp);
        cfg_pb_base   = 8'(pb);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a full tile schedule and checks every cycle against the expected sequence.
    task automatic runSchedule(input int ts, input int in_grp, input int out_grp, input int pb,
                               input int w_dly, input int p_dly, input bit flag_ok, input bit busy_start);
        bit exp_err;
        exp_err = 1'b0;
        applyStimulus(ts, in_grp, out_grp, pb);
        checkOutput("err_cleared_on_start", 32'(err_timeout), 32'd0);
        for (int og = 0; og <= out_grp; og++) begin
            for (int ig = 0; ig <= in_grp; ig++) begin
                checkOutput("load_state", 32'(top_level_state), 32'd1);
                checkOutput("load_w_req", 32'(w_req), 32'd1);
                checkOutput("load_w_grp", 32'(w_grp), 32'((og << 4) | ig));
                checkOutput("load_busy", 32'(busy), 32'd1);
                for (int k = 0; k < w_dly; k++) begin
                    @(negedge clk);
                    checkOutput("w_req_held", 32'(w_req), 32'd1);
                end
                w_ack = 1'b1;
                @(negedge clk);
                w_ack = 1'b0;
                for (int c = 0; c <= ts + 3; c++) begin
                    checkOutput("calc_state", 32'(top_level_state), 32'd3);
                    checkOutput("calc_d_re", 32'(d_re), 32'(c <= ts));
                    checkOutput("calc_d_ra", 32'(d_ra), (c <= ts) ? 32'(ig * (ts + 1) + c) : 32'd0);
                    checkOutput("calc_new_tile", 32'(new_tile), 32'(ig == 0));
                    checkOutput("calc_tile_size", 32'(tile_size), 32'(ts));
                    checkOutput("calc_pb_addr", 32'(pb_addr), 32'(pb));
                    checkOutput("calc_err", 32'(err_timeout), 32'(exp_err));
                    checkOutput("calc_w_req", 32'(w_req), 32'd0);
                    pe_finish_flg = flag_ok && ((c == 1) || (c == ts + 3));
                    if (busy_start && c == 1) begin
                        start         = 1'b1;
                        cfg_tile_size = 8'(ts + 9);
                        cfg_pb_base   = 8'(pb + 1);
                    end
                    @(negedge clk);
                    pe_finish_flg = 1'b0;
                    start         = 1'b0;
                    cfg_tile_size = 8'(ts);
                    cfg_pb_base   = 8'(pb);
                end
                if (!flag_ok) exp_err = 1'b1;
            end
            checkOutput("flush_state", 32'(top_level_state), 32'd4);
            checkOutput("flush_post_req", 32'(post_req), 32'd1);
            checkOutput("flush_err", 32'(err_timeout), 32'(exp_err));
            for (int k = 0; k < p_dly; k++) begin
                @(negedge clk);
                checkOutput("post_req_held", 32'(post_req), 32'd1);
                checkOutput("flush_hold_state", 32'(top_level_state), 32'd4);
            end
            post_ack = 1'b1;
            @(negedge clk);
            post_ack = 1'b0;
        end
        checkOutput("done_state", 32'(top_level_state), 32'd5);
        checkOutput("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("idle_state", 32'(top_level_state), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_err", 32'(err_timeout), 32'(exp_err));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_tile_size = '0;
        cfg_in_grp    = '0;
        cfg_out_grp   = '0;
        cfg_pb_base   = '0;
        w_ack         = 1'b0;
        pe_finish_flg = 1'b0;
        post_ack      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_state", 32'(top_level_state), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_w_req", 32'(w_req), 32'd0);
        checkOutput("rst_d_re", 32'(d_re), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // w_ack while idle must not move the FSM
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        checkOutput("stray_ack_idle", 32'(top_level_state), 32'd0);

        runSchedule(7, 0, 0, 8'h10, 0, 0, 1'b1, 1'b0);
        runSchedule(3, 2, 0, 8'h20, 0, 0, 1'b1, 1'b0);
        runSchedule(5, 0, 1, 8'h30, 1, 5, 1'b1, 1'b0);
        runSchedule(2, 1, 0, 8'h40, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("err_sticky_idle", 32'(err_timeout), 32'd1);
        runSchedule(4, 1, 0, 8'h50, 0, 0, 1'b1, 1'b1);
        runSchedule(0, 0, 0, 8'h60, 3, 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of CALC
        applyStimulus(7, 0, 0, 8'h70);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_state", 32'(top_level_state), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_state", 32'(top_level_state), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_d_re", 32'(d_re), 32'd0);
        checkOutput("arst_d_ra", 32'(d_ra), 32'd0);
        checkOutput("arst_tile_size", 32'(tile_size), 32'd0);
        checkOutput("arst_pb_addr", 32'(pb_addr), 32'd0);
        checkOutput("arst_new_tile", 32'(new_tile), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_state", 32'(top_level_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
